lrwait_queue_ctrl: RTL
======================

LRWAIT_QUEUE_CTRL -- requirements
Module: lrwait_queue_ctrl

Interface
REQ-001 SHALL have parameter AddrWidth, default 32, request address width.
REQ-002 SHALL have parameter DataWidth, default 32, data width.
REQ-003 SHALL have parameter MetaWidth, default 12, requester metadata width, including the return route and meta id.
REQ-004 SHALL have port clk_i, input, 1, sole clock; all logic is on the rising edge.
REQ-005 SHALL have port rst_i, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have ports req_valid_i in 1 / req_ready_o out 1: request handshake from the interconnect.
REQ-007 SHALL have ports req_addr_i in AddrWidth, req_amo_i in 4, req_write_i in 1, req_data_i in DataWidth, req_strb_i in DataWidth/8, req_meta_i in MetaWidth, req_lrwait_i in 1 (WakeUp flag).
REQ-008 SHALL have ports resp_valid_o out 1 / resp_ready_i in 1: response handshake.
REQ-009 SHALL have ports resp_data_o out DataWidth, resp_meta_o out MetaWidth, resp_error_o out 1, resp_lrwait_o out 1 (SuccUpdate flag).
REQ-010 SHALL have ports bank_req_o out 1, bank_addr_o out AddrWidth, bank_wen_o out 1, bank_wdata_o out DataWidth, bank_be_o out DataWidth/8, bank_rdata_i in DataWidth; the bank is always ready and has fixed 1-cycle read latency.

Function
REQ-011 SHALL use amo encodings 4'h0 none, 4'hC LRWAIT, 4'hD SCWAIT; all other codes are plain accesses.
REQ-012 SHALL hold reservation state: res_addr, head_meta, tail_meta, and FSM {Free, Held}.
REQ-013 SHALL keep at most one request in flight: req_ready_o = !resp_valid_o; a request is accepted at cycle t and its response (if any) is valid at t+1 and held until resp_ready_i.
REQ-014 SHALL forward a plain request to the bank unchanged; the response carries bank_rdata_i (0 for writes), req_meta_i, error=0, lrwait=0.
REQ-015 SHALL, on LRWAIT in Free: read the bank, set res_addr=addr, head=tail=req_meta, go Held, and respond with the read data.
REQ-016 SHALL, on LRWAIT in Held with addr==res_addr: issue no bank access; emit a SuccUpdate response with resp_meta_o=old tail_meta, resp_data_o[MetaWidth-1:0]=req_meta_i (upper bits 0), lrwait=1; set tail=req_meta_i; send no response to the requester.
REQ-017 SHALL, on LRWAIT in Held with addr!=res_addr: serve it as a plain load with resp_error_o=1 and leave the queue unchanged.
REQ-018 SHALL, on SCWAIT with state Held, addr==res_addr and meta==head_meta: write the bank with data/strb and respond data=0.
REQ-019 SHALL, in the REQ-018 case, return to Free when tail_meta==head_meta; otherwise remain Held awaiting a WakeUp.
REQ-020 SHALL, on any other SCWAIT: issue no bank write, respond data=1, error=0, and leave state unchanged.
REQ-021 SHALL, on a WakeUp (req_lrwait_i=1) in Held: read the bank at res_addr, set head=req_data_i[MetaWidth-1:0], and respond with the read data to that meta with lrwait=0.
REQ-022 SHALL treat a WakeUp in Free as an error: no bank access, no response, state unchanged.
REQ-023 SHALL leave the queue unaffected by plain stores to res_addr.
REQ-024 SHALL not pass through a response with resp_lrwait_o=1 as a data response; resp_error_o=0 on SuccUpdate.
REQ-025 SHALL hold all response fields stable while resp_valid_o && !resp_ready_i.

Reset
REQ-026 SHALL, on rst_i=1 at a clock edge: set state Free, set res_addr/head/tail to 0, and drive resp_valid_o=0, bank_req_o=0, and req_ready_o=1 the next cycle.
REQ-027 SHALL, on reset mid-operation, discard any pending response and queue without emitting it.
REQ-028 SHALL drive all outputs to 0 during reset except req_ready_o.

Verification
REQ-029 SHALL be verified by: LRWAIT A=0x100, meta 0x011, in Free -> bank read 0x100, resp data=mem, meta 0x011 at t+1, state Held.
REQ-030 SHALL be verified by: then LRWAIT 0x100, meta 0x022 -> no bank access, SuccUpdate meta 0x011, data 0x022, lrwait=1; tail=0x022.
REQ-031 SHALL be verified by: SCWAIT 0x100, meta 0x011, data 5 -> bank write 5, resp data 0, still Held; then WakeUp data 0x022 -> bank read 0x100, resp meta 0x022 data 5, head=0x022.
REQ-032 SHALL be verified by: SCWAIT from meta 0x033 (non-head) -> no write, resp data 1; LRWAIT 0x200 while Held on 0x100 -> resp error=1.
REQ-033 SHALL be verified by: resp_ready_i=0 for 3 cycles -> req_ready_o=0 and response stable; rst_i asserted with a response pending -> resp_valid_o=0 the next cycle, state Free.

Source files
------------

// File: rtl/lrwait_queue_ctrl.sv
// lrwait_queue_ctrl
//   Single-reservation LRWAIT/SCWAIT queue controller sitting in front of a
//   memory bank. One request is in flight at a time: a request accepted in
//   cycle t produces its response (if any) in cycle t+1. The response is held
//   until the interconnect takes it.
//
//   The reservation queue is distributed. This block only remembers the
//   reserved address and the head and tail metadata. Each requester learns
//   who queued behind it from the SuccUpdate response. It then wakes that
//   successor with a WakeUp request carrying the successor's metadata.
//
// State table
//   state | meaning
//   FREE  | no reservation outstanding; res_addr/head/tail are stale
//   HELD  | reservation on res_addr, head_meta owns it, tail_meta is last in queue
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_*                   request channel (valid/ready, address, amo code,
//                           write, data, strobes, requester meta, WakeUp flag)
//   resp_*                  response channel (valid/ready, data, meta, error,
//                           SuccUpdate flag)
//   bank_*                  bank port, always ready, read data one cycle later
module lrwait_queue_ctrl #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int MetaWidth = 12
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [AddrWidth-1:0]   req_addr_i,
  input  logic [3:0]             req_amo_i,
  input  logic                   req_write_i,
  input  logic [DataWidth-1:0]   req_data_i,
  input  logic [DataWidth/8-1:0] req_strb_i,
  input  logic [MetaWidth-1:0]   req_meta_i,
  input  logic                   req_lrwait_i,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output logic [DataWidth-1:0]   resp_data_o,
  output logic [MetaWidth-1:0]   resp_meta_o,
  output logic                   resp_error_o,
  output logic                   resp_lrwait_o,
  output logic                   bank_req_o,
  output logic [AddrWidth-1:0]   bank_addr_o,
  output logic                   bank_wen_o,
  output logic [DataWidth-1:0]   bank_wdata_o,
  output logic [DataWidth/8-1:0] bank_be_o,
  input  logic [DataWidth-1:0]   bank_rdata_i
);

  localparam int StrbWidth = DataWidth / 8;
  localparam logic [3:0] AmoLrWait = 4'hC;
  localparam logic [3:0] AmoScWait = 4'hD;

  typedef enum logic {
    FREE = 1'b0,
    HELD = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   res_addr_q, res_addr_d;
  logic [MetaWidth-1:0]   head_q, head_d;
  logic [MetaWidth-1:0]   tail_q, tail_d;

  logic                   resp_valid_q;
  logic                   from_bank_q;
  logic [DataWidth-1:0]   resp_data_q;
  logic [MetaWidth-1:0]   resp_meta_q;
  logic                   resp_error_q;
  logic                   resp_lrwait_q;

  logic                   accept;
  logic                   is_lrwait;
  logic                   is_scwait;
  logic                   addr_hit;
  logic                   bank_req_d;
  logic                   bank_wen_d;
  logic [AddrWidth-1:0]   bank_addr_d;
  logic [DataWidth-1:0]   bank_wdata_d;
  logic [StrbWidth-1:0]   bank_be_d;
  logic                   load_resp;
  logic                   from_bank_d;
  logic [DataWidth-1:0]   resp_data_d;
  logic [MetaWidth-1:0]   resp_meta_d;
  logic                   resp_error_d;
  logic                   resp_lrwait_d;

  // Request decode. Bank outputs come straight from here so the bank sees
  // the access in the accept cycle and its read data lines up with t+1.
  always_comb begin
    accept        = req_valid_i && !resp_valid_q && !rst_i;
    is_lrwait     = (req_amo_i == AmoLrWait);
    is_scwait     = (req_amo_i == AmoScWait);
    addr_hit      = (req_addr_i == res_addr_q);

    bank_req_d    = 1'b0;
    bank_wen_d    = 1'b0;
    bank_addr_d   = '0;
    bank_wdata_d  = '0;
    bank_be_d     = '0;

    load_resp     = 1'b0;
    from_bank_d   = 1'b0;
    resp_data_d   = '0;
    resp_meta_d   = req_meta_i;
    resp_error_d  = 1'b0;
    resp_lrwait_d = 1'b0;

    state_d       = state_q;
    res_addr_d    = res_addr_q;
    head_d        = head_q;
    tail_d        = tail_q;

    if (accept) begin
      if (req_lrwait_i) begin
        // WakeUp: hand the reservation to the successor named in the data.
        // A WakeUp with nothing reserved is dropped silently.
        if (state_q == HELD) begin
          bank_req_d  = 1'b1;
          bank_addr_d = res_addr_q;
          load_resp   = 1'b1;
          from_bank_d = 1'b1;
          resp_meta_d = req_data_i[MetaWidth-1:0];
          head_d      = req_data_i[MetaWidth-1:0];
        end
      end else if (is_lrwait) begin
        if (state_q == FREE) begin
          bank_req_d  = 1'b1;
          bank_addr_d = req_addr_i;
          load_resp   = 1'b1;
          from_bank_d = 1'b1;
          state_d     = HELD;
          res_addr_d  = req_addr_i;
          head_d      = req_meta_i;
          tail_d      = req_meta_i;
        end else if (addr_hit) begin
          // Enqueue: tell the old tail who its successor is. The new requester
          // gets no reply until it is woken.
          load_resp                    = 1'b1;
          resp_meta_d                  = tail_q;
          resp_data_d[MetaWidth-1:0]   = req_meta_i;
          resp_lrwait_d                = 1'b1;
          tail_d                       = req_meta_i;
        end else begin
          // Only one reservation is tracked; a second address degrades to a
          // load flagged as failed.
          bank_req_d   = 1'b1;
          bank_addr_d  = req_addr_i;
          load_resp    = 1'b1;
          from_bank_d  = 1'b1;
          resp_error_d = 1'b1;
        end
      end else if (is_scwait) begin
        load_resp = 1'b1;
        if ((state_q == HELD) && addr_hit && (req_meta_i == head_q)) begin
          bank_req_d   = 1'b1;
          bank_wen_d   = 1'b1;
          bank_addr_d  = req_addr_i;
          bank_wdata_d = req_data_i;
          bank_be_d    = req_strb_i;
          // Queue empties only when the head was also the tail; otherwise
          // the head keeps ownership until it sends the WakeUp.
          if (tail_q == head_q) begin
            state_d = FREE;
          end
        end else begin
          resp_data_d = DataWidth'(1);
        end
      end else begin
        bank_req_d   = 1'b1;
        bank_wen_d   = req_write_i;
        bank_addr_d  = req_addr_i;
        bank_wdata_d = req_data_i;
        bank_be_d    = req_strb_i;
        load_resp    = 1'b1;
        from_bank_d  = !req_write_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= FREE;
      res_addr_q    <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      resp_valid_q  <= 1'b0;
      from_bank_q   <= 1'b0;
      resp_data_q   <= '0;
      resp_meta_q   <= '0;
      resp_error_q  <= 1'b0;
      resp_lrwait_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      res_addr_q <= res_addr_d;
      head_q     <= head_d;
      tail_q     <= tail_d;

      // Bank read data is only valid in the first response cycle; capture
      // it then so a stalled response keeps showing the same value.
      if (resp_valid_q && from_bank_q) begin
        resp_data_q <= bank_rdata_i;
        from_bank_q <= 1'b0;
      end

      if (resp_valid_q && resp_ready_i) begin
        resp_valid_q <= 1'b0;
      end

      if (load_resp) begin
        resp_valid_q  <= 1'b1;
        from_bank_q   <= from_bank_d;
        resp_data_q   <= resp_data_d;
        resp_meta_q   <= resp_meta_d;
        resp_error_q  <= resp_error_d;
        resp_lrwait_q <= resp_lrwait_d;
      end
    end
  end

  assign req_ready_o   = !resp_valid_q;
  assign resp_valid_o  = resp_valid_q && !rst_i;
  assign resp_data_o   = rst_i ? '0 : (from_bank_q ? bank_rdata_i : resp_data_q);
  assign resp_meta_o   = rst_i ? '0 : resp_meta_q;
  assign resp_error_o  = resp_error_q && !rst_i;
  assign resp_lrwait_o = resp_lrwait_q && !rst_i;

  assign bank_req_o    = bank_req_d;
  assign bank_wen_o    = bank_wen_d;
  assign bank_addr_o   = bank_addr_d;
  assign bank_wdata_o  = bank_wdata_d;
  assign bank_be_o     = bank_be_d;

endmodule
